// File: rtl/significand.sv
`default_nettype none
// ============================================================================
// Module   : significand
// Purpose  : FPU operand unpack, fraction extract plus denormal normalization
// Revision : 1.0
// ============================================================================
module significand #(
  parameter int N = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          dbs,
  input  logic [N-1:0]  x,
  input  logic          ez,
  input  logic          normal,
  output logic [5:0]    lz,
  output logic [52:0]   f,
  output logic          fz,
  output logic [51:0]   h
);

  if (N != 64) begin : g_bad_width
    $error("significand: only N=64 is supported");
  end

  logic [51:0] w_h;
  logic [52:0] w_s;
  logic [63:0] w_lzv;
  logic [63:0] w_mask;
  logic [5:0]  w_cnt;
  logic [5:0]  w_lz;
  logic [52:0] w_sh;
  logic        w_unused;

  assign w_h      = dbs ? x[51:0] : {x[54:32], 29'b0};
  assign w_s      = {normal, w_h};
  assign w_unused = ^x[63:55];

  // Trailing ones cap the count at 53 for an all-zero significand.
  always_comb begin
    w_lzv  = {w_s, 11'h7FF};
    w_cnt  = '0;
    w_mask = '0;
    for (int k = 5; k >= 0; k--) begin
      w_mask = ~({64{1'b1}} >> (1 << k));
      if ((w_lzv & w_mask) == 64'd0) begin
        w_cnt[k] = 1'b1;
        w_lzv    = w_lzv << (1 << k);
      end
    end
  end

  assign w_lz = (ez && (w_s != 53'd0)) ? w_cnt : 6'd0;

  always_comb begin
    w_sh = w_s;
    for (int k = 0; k < 6; k++) begin
      if (w_lz[k]) begin
        w_sh = w_sh << (1 << k);
      end
    end
  end

  logic [5:0]  r_lz;
  logic [52:0] r_f;
  logic        r_fz;
  logic [51:0] r_h;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lz <= '0;
      r_f  <= '0;
      r_fz <= 1'b0;
      r_h  <= '0;
    end else begin
      r_lz <= w_lz;
      r_f  <= w_sh;
      r_fz <= (w_h == 52'd0);
      r_h  <= w_h;
    end
  end

  assign lz = r_lz;
  assign f  = r_f;
  assign fz = r_fz;
  assign h  = r_h;

endmodule
`default_nettype wire

// File: tb/tb_significand.sv
`default_nettype none
// ============================================================================
// Module   : tb_significand
// Purpose  : self-checking bench for significand (vector table + scoreboard)
// Revision : 1.0
// ============================================================================
module tb_significand;

  logic        clk = 1'b0;
  logic        rst;
  logic        dbs;
  logic [63:0] x;
  logic        ez;
  logic        normal;
  logic [5:0]  lz;
  logic [52:0] f;
  logic        fz;
  logic [51:0] h;

  always #5 clk = ~clk;

  significand #(.N(64)) dut (
    .clk    (clk),
    .rst    (rst),
    .dbs    (dbs),
    .x      (x),
    .ez     (ez),
    .normal (normal),
    .lz     (lz),
    .f      (f),
    .fz     (fz),
    .h      (h)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [5:0]  lz;
    logic [52:0] f;
    logic        fz;
    logic [51:0] h;
  } exp_t;

  typedef struct {
    string       name;
    logic        dbs;
    logic [63:0] x;
    logic        ez;
    logic        normal;
    logic [5:0]  lz;
    logic [52:0] f;
    logic        fz;
    logic [51:0] h;
  } vec_t;

  exp_t sb[$];

  task automatic cmp(input string nm, input string fld,
                     input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s: got %h expected %h", nm, fld, act, exp);
    end
  endtask

  task automatic check_zero(input string nm);
    cmp(nm, "lz", {58'd0, lz}, 64'd0);
    cmp(nm, "f",  {11'd0, f},  64'd0);
    cmp(nm, "fz", {63'd0, fz}, 64'd0);
    cmp(nm, "h",  {12'd0, h},  64'd0);
  endtask

  task automatic check_pending();
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      cmp(e.name, "lz", {58'd0, lz}, {58'd0, e.lz});
      cmp(e.name, "f",  {11'd0, f},  {11'd0, e.f});
      cmp(e.name, "fz", {63'd0, fz}, {63'd0, e.fz});
      cmp(e.name, "h",  {12'd0, h},  {12'd0, e.h});
    end
  endtask

  // Inputs change on the falling edge; the previous operand's result is
  // checked at that same falling edge, half a cycle after its capture.
  task automatic drive(input vec_t v);
    exp_t e;
    @(negedge clk);
    check_pending();
    dbs    = v.dbs;
    x      = v.x;
    ez     = v.ez;
    normal = v.normal;
    e.name = v.name;
    e.lz   = v.lz;
    e.f    = v.f;
    e.fz   = v.fz;
    e.h    = v.h;
    sb.push_back(e);
  endtask

  task automatic flush();
    @(negedge clk);
    check_pending();
  endtask

  // Independent reference: bit-serial normalization loop.
  function automatic vec_t model(input string nm, input logic d, input logic [63:0] xx,
                                 input logic e, input logic n);
    vec_t        v;
    logic [52:0] s;
    v.name   = nm;
    v.dbs    = d;
    v.x      = xx;
    v.ez     = e;
    v.normal = n;
    if (d) v.h = xx[51:0];
    else   v.h = {xx[54:32], 29'd0};
    v.fz = (v.h == 52'd0);
    s    = {n, v.h};
    v.lz = 6'd0;
    if (e && s != 53'd0) begin
      for (int i = 0; i < 53; i++) begin
        if (!s[52]) begin
          s    = s << 1;
          v.lz = v.lz + 6'd1;
        end
      end
    end
    v.f = s;
    return v;
  endfunction

  vec_t tbl[8];
  vec_t s2;

  initial begin
    tbl[0] = '{"sgl_a5",   1'b0, 64'hA5A5A5A5A5A5A5A5, 1'b0, 1'b1, 6'd0,
               53'h14B4B4A0000000, 1'b0, 52'h4B4B4A0000000};
    tbl[1] = '{"sgl_dead", 1'b0, 64'hDEADBEEFDEADBEEF, 1'b0, 1'b1, 6'd0,
               53'h15B7DDE0000000, 1'b0, 52'h5B7DDE0000000};
    tbl[2] = '{"dbl_1f",   1'b1, 64'h1F1F1F1F1F1F1F1F, 1'b1, 1'b0, 6'd1,
               53'h1E3E3E3E3E3E3E, 1'b0, 52'hF1F1F1F1F1F1F};
    tbl[3] = '{"dbl_ff",   1'b1, 64'hFFFFFFFFFFFFFFFF, 1'b1, 1'b0, 6'd1,
               53'h1FFFFFFFFFFFFE, 1'b0, 52'hFFFFFFFFFFFFF};
    tbl[4] = '{"dbl_lz52", 1'b1, 64'h0000000000000001, 1'b1, 1'b0, 6'd52,
               53'h10000000000000, 1'b0, 52'h0000000000001};
    tbl[5] = '{"sgl_lz23", 1'b0, 64'h00000001FFFFFFFF, 1'b1, 1'b0, 6'd23,
               53'h10000000000000, 1'b0, 52'h0000020000000};
    tbl[6] = '{"dbl_zero", 1'b1, 64'h0000000000000000, 1'b1, 1'b0, 6'd0,
               53'h0, 1'b1, 52'h0};
    tbl[7] = '{"sgl_zero", 1'b0, 64'h8000000012345678, 1'b1, 1'b0, 6'd0,
               53'h0, 1'b1, 52'h0};
    s2 = tbl[0];

    rst = 1'b0; dbs = 1'b0; x = '0; ez = 1'b0; normal = 1'b0;
    #1 rst = 1'b1;
    #1 check_zero("reset_init");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) drive(tbl[i]);
    flush();

    // ez=1 with normal=1 is tolerated: MSB already set, no shift.
    drive(model("ez_norm", 1'b1, 64'h0000000000000123, 1'b1, 1'b1));
    // ez=0 keeps a denormal-looking fraction unshifted.
    drive(model("ez0_den", 1'b1, 64'h0000000000000123, 1'b0, 1'b0));
    for (int i = 0; i < 12; i++) begin
      drive(model($sformatf("alt%0d", i), i[0], {$urandom, $urandom} >> (i * 4),
                  ~i[1], i[1]));
    end
    flush();

    // Mid-stream asynchronous reset: outputs clear while clk is high.
    drive(tbl[1]);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_zero("reset_mid");
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    drive(s2);
    flush();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/significand.md
Name: significand

Overview:
- Significand unpacker for the FPU operand unpack stage.
- Takes a packed IEEE operand and extracts the fraction field: double format (dbs=1) or single format (dbs=0).
- Produces three registered results:
  - the 52-bit left-aligned fraction;
  - the zero-fraction flag;
  - the 53-bit normalized significand with its leading-zero count, which the exponent path uses to adjust denormals.

Parameters:
- N, 64, operand width. Only 64 is supported; any other value is a configuration error.

Ports:
- clk  input  1  clock; all outputs update on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- dbs  input  1  1 = double-precision operand, 0 = single-precision operand.
- x  input  N  packed operand. Double uses x[63:0]; single occupies x[63:32] and ignores x[31:0].
- ez  input  1  exponent field is all zeros (denormal or zero); enables normalization.
- normal  input  1  hidden bit value: 1 for normal numbers, 0 for denormal or zero.
- lz  output  6  leading-zero count applied to produce f (0..52).
- f  output  53  normalized significand {hidden, fraction} << lz.
- fz  output  1  fraction field is zero.
- h  output  52  raw fraction, left-aligned.

Behaviour:
- Reset: asynchronous on rst=1. lz=0, f=0, fz=0, h=0, held while rst is high. First capture happens on the first rising clk edge after rst deasserts.
- Latency: 1 cycle. Inputs are sampled on rising clk and the results are visible after that edge. There is no handshake; a new operand is accepted every cycle.
- Fraction extract (combinational, then registered):
  - dbs=1: h = x[51:0].
  - dbs=0: h = {x[54:32], 29'b0}, i.e. the 23-bit single fraction MSB-aligned to h[51].
- fz = 1 iff h == 0. For single format this depends only on x[54:32].
- Raw significand s[52:0] = {normal, h}.
- When ez=0:
  - lz = 0 and f = s, regardless of the fraction value.
- When ez=1:
  - lz = number of leading zeros of s, counting from bit 52.
  - f = s << lz, so f[52]=1 whenever s != 0.
- Zero case: s == 0 gives lz = 0, f = 0, and fz = 1 (if normal=0).
- ez=1 with normal=1 is an illegal combination upstream. The block still computes deterministically: lz=0 and f=s, because the MSB is already set.
- Leading-zero counter: 53-bit priority encoder built from a log-depth tree (6-bit result). Shifter: 53-bit barrel shifter with 6 stages (1, 2, 4, 8, 16, 32); bits shifted in are 0.
- Maximum lz is 52 (only s[0] set). This is reachable in double format only. Single format yields lz ≤ 23 when fz=0.
- Changing dbs between consecutive cycles needs no pipeline flush; each cycle is independent.

Test Plan:
1. Reset with rst=1 mid-stream → all outputs 0 immediately, without waiting for clk. Deassert rst, then apply the scenario 2 inputs → outputs valid one edge later.
2. dbs=0, x=64'hA5A5A5A5A5A5A5A5, ez=0, normal=1 → after 1 clk: h=52'h4B4B4A0000000, f=53'h14B4B4A0000000, lz=0, fz=0.
3. dbs=0, x=64'hDEADBEEFDEADBEEF, ez=0, normal=1 → h=52'h5B7DDE0000000, f=53'h15B7DDE0000000, lz=0, fz=0.
4. dbs=1, x=64'h1F1F1F1F1F1F1F1F, ez=1, normal=0 → h=52'hF1F1F1F1F1F1F, lz=1, f=53'h1E3E3E3E3E3E3E, fz=0. Same test with x=64'hFFFFFFFFFFFFFFFF → h=52'hFFFFFFFFFFFFF, lz=1, f=53'h1FFFFFFFFFFFFE.
5. Denormal extremes:
   - dbs=1, x=64'h1, ez=1, normal=0 → lz=52, f=53'h10000000000000, h=52'h1, fz=0.
   - dbs=0, x=64'h00000001_FFFFFFFF, ez=1, normal=0 → h=52'h0000020000000, lz=23, f=53'h10000000000000, fz=0. This also confirms that x[31:0] is ignored.
6. Zero operands:
   - dbs=1, x=0, ez=1, normal=0 → h=0, f=0, lz=0, fz=1.
   - dbs=0, x=64'h80000000_12345678, ez=1, normal=0 → fz=1, f=0, lz=0.
   - Back-to-back alternation of dbs each cycle → every result matches its own input, one cycle later.
